// File: rtl/fifo_rd_prefetch_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_prefetch_pkg
// Shared defaults and helpers for the FIFO read-prefetch block.
//   DAT_WIDTH_DEF : data word width (26-bit FIFO envelope)
//   BUF_DEPTH_DEF : number of output buffer entries (legal 2..8)
//   CNT_WIDTH_DEF : width of the delivered-word counter
//   ptr_width()   : width of a circular pointer into a buffer of given depth
// -----------------------------------------------------------------------------
package fifo_rd_prefetch_pkg;

   localparam int DAT_WIDTH_DEF = 26;
   localparam int BUF_DEPTH_DEF = 3;
   localparam int CNT_WIDTH_DEF = 16;

   // Pointer width for a buffer of 'depth' entries; never narrower than 1 bit.
   function automatic int ptr_width(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage : fifo_rd_prefetch_pkg

// File: rtl/fifo_rd_prefetch_regfile.sv
// -----------------------------------------------------------------------------
// fifo_rd_prefetch_regfile
// Output buffer storage: BUF_DEPTH entries with circular write and read
// pointers, one synchronous write port and one registered-array read port.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset (clears entries and pointers)
//   clear    : synchronous pointer clear (flush); entries are left as-is
//   wr_en    : write wr_data at the write pointer and advance it
//   wr_data  : word to store
//   rd_adv   : advance the read pointer (head word consumed)
//   rd_data  : entry at the read pointer
// -----------------------------------------------------------------------------
module fifo_rd_prefetch_regfile
   import fifo_rd_prefetch_pkg::*;
#(
   parameter int DAT_WIDTH = DAT_WIDTH_DEF,
   parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 wr_en,
   input  logic [DAT_WIDTH-1:0] wr_data,
   input  logic                 rd_adv,
   output logic [DAT_WIDTH-1:0] rd_data
);

   localparam int               PTR_W = ptr_width(BUF_DEPTH);
   localparam logic [PTR_W-1:0] LAST  = PTR_W'(BUF_DEPTH - 1);

   logic [DAT_WIDTH-1:0] mem [BUF_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;

   // Depth need not be a power of two, so wrap explicitly at the last entry.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   // NOTE: the entries are reset on purpose -- out_data is read straight from
   // the array and must read zero while reset is held. Flush only clears the
   // pointers, since stale entries are hidden behind out_valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en && !clear) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // NOTE: sequential state is assigned only with non-blocking (<=) so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en)  wr_ptr <= ptr_next(wr_ptr);
         if (rd_adv) rd_ptr <= ptr_next(rd_ptr);
      end
   end

   // Mux of registers only: no combinational path from wr_data to rd_data.
   assign rd_data = mem[rd_ptr];

endmodule : fifo_rd_prefetch_regfile

// File: rtl/fifo_rd_prefetch_a26.sv
// -----------------------------------------------------------------------------
// fifo_rd_prefetch_a26
// Read-side prefetcher for a FIFO envelope whose RAM data arrives one cycle
// after the read strobe. Words are prefetched into a small output buffer and
// presented downstream with a valid/ready handshake.
// Ports:
//   clk          : clock, rising edge
//   reset        : synchronous active-high reset
//   fifo_empty   : upstream FIFO empty flag
//   fifo_rd_op   : read strobe to the FIFO (one word popped per high cycle)
//   fifo_rd_data : RAM read data, valid the cycle after fifo_rd_op
//   flush        : discard all buffered and in-flight words
//   out_valid    : out_data holds a valid word
//   out_ready    : downstream accepts the word
//   out_data     : head word of the buffer
//   buf_count    : occupied buffer entries
//   out_cnt      : completed output handshakes (wraps)
// -----------------------------------------------------------------------------
module fifo_rd_prefetch_a26
   import fifo_rd_prefetch_pkg::*;
#(
   parameter int DAT_WIDTH = DAT_WIDTH_DEF,
   parameter int BUF_DEPTH = BUF_DEPTH_DEF,
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             fifo_empty,
   output logic                             fifo_rd_op,
   input  logic [DAT_WIDTH-1:0]             fifo_rd_data,
   input  logic                             flush,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DAT_WIDTH-1:0]             out_data,
   output logic [$clog2(BUF_DEPTH+1)-1:0]   buf_count,
   output logic [CNT_WIDTH-1:0]             out_cnt
);

   localparam int            CW      = $clog2(BUF_DEPTH + 1);
   localparam logic [CW:0]   OCC_MAX = (CW + 1)'(BUF_DEPTH);
   localparam logic [CW-1:0] FULL    = CW'(BUF_DEPTH);

   if (BUF_DEPTH < 2 || BUF_DEPTH > 8) begin : g_depth_check
      $error("fifo_rd_prefetch_a26: BUF_DEPTH must be in 2..8");
   end

   logic [CW-1:0] count;
   logic          inflight;
   logic [CW:0]   occupancy;
   logic          wr_en;
   logic          pop;

   // Reserve an entry for the word still in flight so the buffer can never
   // be overrun; out_ready is deliberately absent from this path.
   assign occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};
   assign fifo_rd_op = !fifo_empty && !flush && !reset && (occupancy < OCC_MAX);

   assign wr_en     = inflight && !flush;
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready && !flush;
   assign buf_count = count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count    <= '0;
         inflight <= 1'b0;
         out_cnt  <= '0;
      end else if (flush) begin
         // Handshake counter survives a flush; only buffer state is dropped.
         count    <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= fifo_rd_op;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (pop) out_cnt <= out_cnt + 1'b1;
      end
   end

   fifo_rd_prefetch_regfile #(
      .DAT_WIDTH (DAT_WIDTH),
      .BUF_DEPTH (BUF_DEPTH)
   ) u_regfile (
      .clk     (clk),
      .reset   (reset),
      .clear   (flush),
      .wr_en   (wr_en),
      .wr_data (fifo_rd_data),
      .rd_adv  (pop),
      .rd_data (out_data)
   );

   // A write arriving while every entry is occupied means the read-ahead
   // accounting above is broken.
   a_no_overflow : assert property (@(posedge clk) disable iff (reset)
      !(wr_en && (count == FULL)));

endmodule : fifo_rd_prefetch_a26

// File: tb/tb_fifo_rd_prefetch_a26.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_prefetch_a26
// Self-checking bench: an upstream FIFO model feeds the prefetcher, and a
// queue-based reference model predicts read strobes, occupancy, handshake
// count and the delivered word order.
// -----------------------------------------------------------------------------
module tb_fifo_rd_prefetch_a26;

   localparam int DW    = 26;
   localparam int DEPTH = 3;
   localparam int CNTW  = 16;
   localparam int BCW   = $clog2(DEPTH + 1);

   typedef logic [DW-1:0] word_t;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            fifo_empty;
   logic            fifo_rd_op;
   word_t           fifo_rd_data = '0;
   logic            flush = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   word_t           out_data;
   logic [BCW-1:0]  buf_count;
   logic [CNTW-1:0] out_cnt;

   // Upstream FIFO model
   logic  hold_empty = 1'b1;
   int    src_n = 0;
   word_t src_q[$];
   assign fifo_empty = hold_empty || (src_n == 0);

   // Reference model state
   word_t           exp_q[$];
   logic            m_inflight = 1'b0;
   word_t           m_word = '0;
   logic [CNTW-1:0] exp_cnt = '0;

   // Values sampled mid-cycle by step()
   logic  s_rd_op, s_valid;
   int    s_count, s_cnt;
   word_t s_data;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   fifo_rd_prefetch_a26 #(
      .DAT_WIDTH (DW),
      .BUF_DEPTH (DEPTH),
      .CNT_WIDTH (CNTW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .fifo_empty   (fifo_empty),
      .fifo_rd_op   (fifo_rd_op),
      .fifo_rd_data (fifo_rd_data),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .buf_count    (buf_count),
      .out_cnt      (out_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic load(input word_t w);
      src_q.push_back(w);
      src_n = src_q.size();
   endtask

   // One clock cycle: check the DUT against the model at the falling edge,
   // advance the model to the next rising edge, then play the upstream RAM.
   task automatic step();
      logic exp_rd;
      logic pending_pop;
      @(negedge clk);
      cyc++;
      s_rd_op = fifo_rd_op;
      s_valid = out_valid;
      s_count = int'(buf_count);
      s_cnt   = int'(out_cnt);
      s_data  = out_data;
      exp_rd  = !fifo_empty && !flush && !reset &&
                ((exp_q.size() + int'(m_inflight)) < DEPTH);
      check("rd_op", 32'(fifo_rd_op), 32'(exp_rd));
      if (!reset) begin
         check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
         check("buf_count", 32'(buf_count), 32'(exp_q.size()));
         check("out_cnt", 32'(out_cnt), 32'(exp_cnt));
         if (exp_q.size() != 0) check("out_data", 32'(out_data), 32'(exp_q[0]));
      end
      pending_pop = fifo_rd_op;
      if (reset) begin
         exp_q.delete();
         m_inflight = 1'b0;
         exp_cnt    = '0;
      end else if (flush) begin
         exp_q.delete();
         m_inflight = 1'b0;
      end else begin
         if (exp_q.size() != 0 && out_ready) begin
            void'(exp_q.pop_front());
            exp_cnt = exp_cnt + 1'b1;
         end
         if (m_inflight) exp_q.push_back(m_word);
         m_inflight = pending_pop;
      end
      @(posedge clk);
      #1;
      if (pending_pop && src_q.size() != 0) begin
         m_word       = src_q.pop_front();
         fifo_rd_data = m_word;
      end else begin
         fifo_rd_data = DW'($urandom);
      end
      src_n = src_q.size();
   endtask

   initial begin
      int first_op, first_v, last_v, nv, pulses;

      // Reset state
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
      check("rst_rd_op", 32'(s_rd_op), 32'd0);
      check("rst_valid", 32'(s_valid), 32'd0);
      check("rst_count", 32'(s_count), 32'd0);
      check("rst_out_cnt", 32'(s_cnt), 32'd0);
      check("rst_out_data", 32'(s_data), 32'd0);

      // Streaming: 10 words, out_ready held high
      reset = 1'b1;
      for (int i = 1; i <= 10; i++) load(word_t'(i));
      hold_empty = 1'b0;
      out_ready  = 1'b1;
      step();
      reset = 1'b0;
      first_op = -1; first_v = -1; last_v = -1; nv = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (s_rd_op && first_op < 0) first_op = cyc;
         if (s_valid) begin
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
            nv++;
         end
      end
      check("stream_latency", 32'(first_v - first_op), 32'd2);
      check("stream_words", 32'(nv), 32'd10);
      check("stream_consecutive", 32'(last_v - first_v), 32'd9);
      check("stream_out_cnt", 32'(s_cnt), 32'd10);

      // Flush with a read in flight: strobes in N-1 and N, flush in N+1
      out_ready  = 1'b0;
      hold_empty = 1'b1;
      for (int i = 0; i < 4; i++) load(word_t'(32'h200 + i));
      step();
      hold_empty = 1'b0;
      step();
      step();
      check("flush_rd_op_n", 32'(s_rd_op), 32'd1);
      flush      = 1'b1;
      hold_empty = 1'b1;
      step();
      check("flush_blocks_rd_op", 32'(s_rd_op), 32'd0);
      flush = 1'b0;
      step();
      check("flush_count", 32'(s_count), 32'd0);
      check("flush_valid", 32'(s_valid), 32'd0);
      check("flush_out_cnt", 32'(s_cnt), 32'd10);
      src_q.delete();
      src_n = 0;

      // Empty upstream for 20 cycles
      hold_empty = 1'b1;
      out_ready  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         check("empty_rd_op", 32'(s_rd_op), 32'd0);
      end

      // Backpressure: 6 words, out_ready low
      reset = 1'b1;
      for (int i = 0; i < 6; i++) load(word_t'(32'h100 + i));
      out_ready  = 1'b0;
      hold_empty = 1'b0;
      step();
      reset  = 1'b0;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (s_rd_op) pulses++;
      end
      check("bp_pulses", 32'(pulses), 32'd3);
      check("bp_count", 32'(s_count), 32'd3);
      check("bp_head", 32'(s_data), 32'h100);
      out_ready = 1'b1;
      for (int i = 0; i < 40 && (src_q.size() != 0 || exp_q.size() != 0 || m_inflight); i++) step();
      step();
      check("bp_out_cnt", 32'(s_cnt), 32'd6);

      // Reset mid-stream with two buffered words and one in flight
      reset = 1'b1;
      for (int i = 0; i < 8; i++) load(word_t'(32'h300 + i));
      out_ready  = 1'b0;
      hold_empty = 1'b0;
      step();
      reset = 1'b0;
      step();
      step();
      step();
      reset = 1'b1;
      step();
      check("rmid_count", 32'(s_count), 32'd2);
      reset      = 1'b0;
      hold_empty = 1'b1;
      step();
      check("rmid_rd_op", 32'(s_rd_op), 32'd0);
      check("rmid_valid", 32'(s_valid), 32'd0);
      check("rmid_count0", 32'(s_count), 32'd0);
      check("rmid_out_cnt", 32'(s_cnt), 32'd0);
      check("rmid_out_data", 32'(s_data), 32'd0);
      hold_empty = 1'b0;
      out_ready  = 1'b1;
      for (int i = 0; i < 40 && (src_q.size() != 0 || exp_q.size() != 0 || m_inflight); i++) step();
      step();
      check("rmid_delivered", 32'(s_cnt), 32'd5);

      // Wrap: 1000 random words, random out_ready
      reset = 1'b1;
      src_q.delete();
      for (int i = 0; i < 1000; i++) load(DW'($urandom));
      hold_empty = 1'b0;
      step();
      reset = 1'b0;
      for (int i = 0; i < 8000 && exp_cnt != 16'd1000; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         step();
      end
      out_ready = 1'b0;
      step();
      check("wrap_out_cnt", 32'(s_cnt), 32'd1000);
      check("wrap_buf_empty", 32'(s_count), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_fifo_rd_prefetch_a26

// File: doc/fifo_rd_prefetch_a26.md
FIFO_RD_PREFETCH_A26 -- requirements
Module: fifo_rd_prefetch_a26

Interface
REQ-001 Parameter DAT_WIDTH, default 26, SHALL set the data word width, matching the 26-bit FIFO envelope.
REQ-002 Parameter BUF_DEPTH, default 3, SHALL set the number of output buffer entries; legal range is 2..8.
REQ-003 Parameter CNT_WIDTH, default 16, SHALL set the width of the delivered-word counter.
REQ-004 clk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-005 reset, input, 1: synchronous, active-high reset.
REQ-006 fifo_empty, input, 1: empty flag from the upstream FIFO envelope.
REQ-007 fifo_rd_op, output, 1: read strobe to the FIFO envelope; one word is popped per high cycle.
REQ-008 fifo_rd_data, input, DAT_WIDTH: RAM read data, valid exactly 1 cycle after fifo_rd_op.
REQ-009 flush, input, 1: discard all buffered and in-flight words.
REQ-010 out_valid, output, 1: out_data holds a valid word.
REQ-011 out_ready, input, 1: the downstream consumer accepts the word.
REQ-012 out_data, output, DAT_WIDTH: head word of the buffer.
REQ-013 buf_count, output, clog2(BUF_DEPTH+1): number of occupied buffer entries.
REQ-014 out_cnt, output, CNT_WIDTH: count of completed output handshakes.

Function
REQ-015 State: buffer occupancy count (0..BUF_DEPTH), a 1-bit inflight register, and circular write and read pointers.
REQ-016 fifo_rd_op SHALL be (!fifo_empty && !flush && !reset && (count + inflight) < BUF_DEPTH).
REQ-017 fifo_rd_op SHALL have no combinational path from out_ready.
REQ-018 inflight SHALL be set to the value of fifo_rd_op at each edge; it is therefore high in the cycle that fifo_rd_data is valid.
REQ-019 When inflight=1 and flush=0, fifo_rd_data SHALL be written to the entry at the write pointer, and the write pointer SHALL advance with wrap from BUF_DEPTH-1 to 0.
REQ-020 out_valid SHALL equal (count != 0).
REQ-021 out_data SHALL be the entry at the read pointer, driven from a register with no combinational path from fifo_rd_data.
REQ-022 A pop occurs when out_valid && out_ready && !flush; on a pop the read pointer SHALL advance with wrap.
REQ-023 On each pop, out_cnt SHALL increment by 1, wrapping modulo 2^CNT_WIDTH.
REQ-024 A simultaneous write and pop SHALL leave count unchanged; otherwise count changes by +1 on a write and -1 on a pop.
REQ-025 Minimum latency: fifo_empty falls in cycle N, fifo_rd_op is high in N, data is captured at the end of N+1, and out_valid is high in N+2.
REQ-026 With out_ready held high and the FIFO non-empty, throughput SHALL be 1 word per cycle when BUF_DEPTH >= 3.
REQ-027 Overflow is impossible by construction; a write into a full buffer is a design error and SHALL be flagged by an assertion.
REQ-028 flush high in cycle N SHALL force fifo_rd_op=0 in N and block any pop in N.
REQ-029 flush high in cycle N SHALL discard any data arriving in N.
REQ-030 flush high in cycle N SHALL clear count, inflight and both pointers at the end of N.
REQ-031 out_cnt SHALL be preserved across a flush.
REQ-032 The word count across the interface SHALL be conserved: every fifo_rd_op not covered by REQ-029 produces exactly one buffered word.
REQ-033 out_data and out_valid SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-034 While reset is high: fifo_rd_op=0, out_valid=0, buf_count=0, out_cnt=0, inflight=0, pointers=0, all entries=0, and out_data=0.
REQ-035 Reset asserted mid-transfer SHALL discard in-flight data, with the same effect as flush.
REQ-036 fifo_rd_op MAY assert in the first cycle after reset deasserts.

Structure
REQ-037 A shared package fifo_rd_prefetch_pkg SHALL hold the DAT_WIDTH, BUF_DEPTH and CNT_WIDTH defaults and a pointer-width function.
REQ-038 The entry array and pointers SHALL be placed in one sub-module, fifo_rd_prefetch_regfile (1 write, 1 read, synchronous write).
REQ-039 The control logic (count, inflight, flush, out_cnt) SHALL reside in the top level.

Verification
REQ-040 Streaming: load 10 words 0x0000001..0x000000A, fifo_empty=0, out_ready=1. Expect the first out_valid 2 cycles after the first fifo_rd_op, then 10 consecutive words in order, and out_cnt=10.
REQ-041 Backpressure: out_ready=0 with the FIFO non-empty. Expect exactly 3 fifo_rd_op pulses, buf_count=3, out_data=word0 held stable; on release, words 0..2 then 3.. delivered with no loss.
REQ-042 Flush with a read in flight: fifo_rd_op in cycle N, flush in N+1. Expect the N+1 data dropped, buf_count=0 at N+2, and out_cnt unchanged.
REQ-043 Wrap: 1000 words with random out_ready (50%). Expect data order preserved, pointer wrap exercised, and out_cnt=1000.
REQ-044 Empty: fifo_empty=1 for 20 cycles. Expect fifo_rd_op=0 throughout; fifo_rd_op is never high while fifo_empty=1 (assertion).
REQ-045 Reset mid-stream with buf_count=2 and inflight=1. Expect all outputs 0 the cycle after reset, and no stale word delivered afterwards.
